// File: rtl/mul_seq_nbit.sv
// mul_seq_nbit: sequential shift-add unsigned multiplier, one multiplier bit per clock
// Ports: clk, rst (sync, active-high), start, in1/in2 (WIDTH-bit operands),
//        busy (high in CALC), done (one-cycle pulse), mul (2*WIDTH-bit registered product).
// Define MUL_EARLY_TERM_EN to finish CALC as soon as no set multiplier bits remain.
module mul_seq_nbit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] mul
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] a;
    logic [WIDTH-1:0]   b;
    logic [CW-1:0]      cnt;
    logic               last;
`ifdef MUL_EARLY_TERM_EN
    // b still holds the bit being processed, so look at what remains above it
    assign last = ((b >> 1) == '0) || (cnt == CW'(WIDTH - 1));
`else
    assign last = cnt == CW'(WIDTH - 1);
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            mul   <= '0;
            acc   <= '0;
            a     <= '0;
            b     <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a     <= {{WIDTH{1'b0}}, in1};
                    b     <= in2;
                    acc   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= CALC;
                end
                CALC: begin
                    acc <= b[0] ? acc + a : acc;
                    a   <= a << 1;
                    b   <= b >> 1;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    mul   <= acc;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mul_seq_nbit.md
MUL_SEQ_NBIT -- requirements
Module: mul_seq_nbit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port in1, input, WIDTH, unsigned multiplicand; captured on start acceptance.
REQ-006 SHALL have port in2, input, WIDTH, unsigned multiplier; captured on start acceptance.
REQ-007 SHALL have port busy, output, 1, high while in CALC state.
REQ-008 SHALL have port done, output, 1, one-cycle pulse; product valid in that cycle.
REQ-009 SHALL have port mul, output, 2*WIDTH, registered unsigned product in1*in2.

Function
REQ-010 SHALL implement an FSM with states IDLE, CALC and DONE, using shift-add iteration with one multiplier bit per clock.
REQ-011 In IDLE, start=1 at a rising edge SHALL latch in1 and in2, clear the accumulator and bit counter, and enter CALC.
REQ-012 In CALC, each cycle SHALL add (multiplicand << i) to the 2*WIDTH-bit accumulator when multiplier bit i is 1; i SHALL run 0..WIDTH-1.
REQ-013 The accumulator SHALL be exactly 2*WIDTH bits; no overflow is possible; no truncation is permitted.
REQ-014 After WIDTH CALC cycles, the FSM SHALL enter DONE, load mul with the final accumulator, and assert done for exactly one cycle.
REQ-015 From DONE, the FSM SHALL return to IDLE unconditionally; start asserted during DONE SHALL be ignored.
REQ-016 Latency SHALL be fixed: with start accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH+1.
REQ-017 start, in1 and in2 SHALL be ignored while busy=1; changes to in1 and in2 after acceptance SHALL not affect the result.
REQ-018 mul SHALL hold its value from DONE until the next DONE; it SHALL not change during CALC.
REQ-019 Back-to-back operation SHALL be possible: start held high SHALL be accepted on the first IDLE cycle after DONE.

Reset
REQ-020 rst=1 at a rising edge SHALL force state IDLE, busy=0, done=0, mul=0, accumulator=0 and counter=0.
REQ-021 rst SHALL take priority over start and over any in-progress CALC; the aborted operation SHALL produce no done pulse.
REQ-022 The first start SHALL be accepted on the first edge with rst=0.

Configuration
REQ-023 The macro MUL_EARLY_TERM_EN, when defined, SHALL enable early termination: in CALC, if the remaining (unprocessed, shifted) multiplier bits are all zero after the current step, the next state SHALL be DONE.
REQ-024 With MUL_EARLY_TERM_EN defined, latency SHALL be (index of highest set bit of in2)+1 CALC cycles, with a minimum of 1 (in2=0 gives 1 CALC cycle).
REQ-025 With MUL_EARLY_TERM_EN undefined, latency SHALL be fixed per REQ-016 regardless of operand values; the product SHALL be identical in both builds.

Verification
REQ-026 WIDTH=8, in1=255, in2=255, start one cycle: mul=16'hFE01 and done is high exactly 9 cycles after acceptance; busy is high for 8 cycles.
REQ-027 WIDTH=8, in1=8'hA5, in2=0: mul=0 with one done pulse; with MUL_EARLY_TERM_EN defined, done follows after 1 CALC cycle.
REQ-028 Start accepted with 200*3; start is re-pulsed with in1=7, in2=7 while busy=1: mul=600 and only one done pulse occurs.
REQ-029 rst is asserted at CALC cycle 4 of 100*100: busy=0, done=0 and mul=0 on the next cycle; no done pulse follows; the next start with 12*12 gives mul=144.
REQ-030 WIDTH=16, in1=in2=16'hFFFF: mul=32'hFFFE0001 after 16 CALC cycles; with MUL_EARLY_TERM_EN defined, in2=16'h0001 gives done after 1 CALC cycle with mul=16'hFFFF.
